aes_mem_sequencer: RTL and testbench
====================================

# aes_mem_sequencer

Controller that runs one AES-128 encryption directly out of the shared 64x8 system memory. On a start command it fetches a 16-byte key and a 16-byte plaintext block through the memory request/grant port and assembles them into 128-bit words. It then launches the AES core, waits for completion with a timeout, and writes the 16-byte ciphertext back to memory. It sits between the memory arbiter, where it is one requester alongside the UART path, and the AES core (N=128, Nk=4, Nr=10).

## Interface
- DATA_WIDTH, 8, memory byte width
- MEM_DEPTH, 64, memory depth in bytes
- ADDR_WIDTH, $clog2(MEM_DEPTH)=6, memory address width
- N, 128, AES block/key width
- TIMEOUT, 64, maximum cycles spent in WAIT before error
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  command strobe; sampled only in IDLE
- key_base, pt_base, ct_base  in  ADDR_WIDTH each  base addresses of key, plaintext and ciphertext; sampled on the accepted start
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_WIDTH  access address
- mem_wdata  out  DATA_WIDTH  write data
- mem_gnt  in  1  request accepted this cycle
- mem_rdata  in  DATA_WIDTH  read data, valid the cycle after a granted read
- aes_start  out  1  one-cycle launch pulse
- aes_key, aes_pt  out  N each  operands; stable from RUN until WAIT exits
- aes_done  in  1  core completion strobe
- aes_ct  in  N  ciphertext, valid when aes_done=1
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  timeout flag; held until the next accepted start

## Operation
- States: IDLE, LOAD, DRAIN, RUN, WAIT, STORE, DONE.
- IDLE:
  - start=1: latch bases, clear err and counters, go to LOAD.
  - start in any other state is ignored.
- LOAD issues 32 reads: key bytes 0..15 at key_base+i, then plaintext bytes 0..15 at pt_base+i.
  - Issue counter advances only on mem_gnt. mem_req, mem_addr and mem_we are held until granted.
  - Reads are pipelined. A registered grant flag captures mem_rdata on the cycle after each granted read.
  - After the 32nd grant, go to DRAIN, which captures the last byte.
- Byte packing: byte i goes to bits [N-1-8i -: 8] (byte 0 = MSB).
- Addresses are base+i mod MEM_DEPTH (6-bit wrap: 63 -> 0).
- RUN: aes_start=1 for exactly one cycle, then WAIT.
- WAIT:
  - aes_done=1: capture aes_ct, go to STORE.
  - TIMEOUT cycles elapse without aes_done: set err=1 and go directly to DONE (no writes).
  - aes_done is ignored outside WAIT.
- STORE: 16 writes, mem_we=1, mem_addr=ct_base+i, mem_wdata = ciphertext byte i (same MSB-first packing). Advances on mem_gnt; after the 16th grant, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Reset (asynchronous, any state):
  - state=IDLE; all outputs 0, including aes_key, aes_pt and err.
  - The operation is abandoned; bytes already written stay in memory.

## Timing
- Reset value of every output: 0.
- With mem_gnt held at 1 and start accepted in cycle 0:
  - LOAD: cycles 1-32
  - DRAIN: cycle 33
  - RUN: cycle 34 (aes_start=1)
  - WAIT: from cycle 35
- aes_done sampled in cycle k: STORE k+1..k+16, done=1 in cycle k+17.
- Timeout: WAIT occupies cycles 35..34+TIMEOUT; DONE with err=1 in cycle 35+TIMEOUT (99 at default).
- Each mem_gnt=0 cycle during LOAD or STORE extends that phase by exactly one cycle.
- mem_req=0 in every state except LOAD and STORE.

## Test plan
- FIPS-197 vector: key 2b7e151628aed2a6abf7158809cf4f3c at key_base=0, pt 3243f6a8885a308d313198a2e0370734 at pt_base=16, ct_base=32, mem_gnt=1, AES model done 10 cycles after start -> aes_key/aes_pt match the vectors; bytes 32..47 = 3925841d02dc09fbdc118597196a0b32; done in cycle 62.
- Same vector with random 50% mem_gnt -> identical memory result; no address skipped or repeated; requests held stable while ungranted.
- pt_base=56, ct_base=60 -> reads 56..63 then 0..7; writes 60..63 then 0..11.
- aes_done never asserted -> done in cycle 99, err=1, mem_we never 1; next start clears err.
- rst asserted after the 5th STORE write -> all outputs 0 immediately; only ct_base..ct_base+4 written; a new start completes normally.
- start pulsed during WAIT and during DONE -> ignored; exactly one done per accepted start.

Source files
------------

// File: rtl/aes_mem_sequencer.sv
// Memory-driven AES-128 sequencer: fetches key and plaintext bytes through the
// shared memory port, launches the AES core, and writes the ciphertext back.
module aes_mem_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 64,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int N          = 128,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] key_base,
    input  logic [ADDR_WIDTH-1:0] pt_base,
    input  logic [ADDR_WIDTH-1:0] ct_base,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  aes_start,
    output logic [N-1:0]          aes_key,
    output logic [N-1:0]          aes_pt,
    input  logic                  aes_done,
    input  logic [N-1:0]          aes_ct,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int WAIT_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DRAIN = 3'd2,
        S_RUN   = 3'd3,
        S_WAIT  = 3'd4,
        S_STORE = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t                state_r;
    logic [4:0]            cnt_r;
    logic [4:0]            rd_idx_r;
    logic                  rd_vld_r;
    logic [WAIT_W-1:0]     wait_cnt_r;
    logic [ADDR_WIDTH-1:0] key_base_r;
    logic [ADDR_WIDTH-1:0] pt_base_r;
    logic [ADDR_WIDTH-1:0] ct_base_r;
    logic [N-1:0]          key_r;
    logic [N-1:0]          pt_r;
    logic [N-1:0]          ct_r;
    logic                  mem_req_r;
    logic                  mem_we_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [DATA_WIDTH-1:0] mem_wdata_r;
    logic                  aes_start_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  err_r;

    // Fetch index 0..15 maps to the key, 16..31 to the plaintext; the add wraps mod MEM_DEPTH.
    function automatic logic [ADDR_WIDTH-1:0] load_addr(input logic [4:0] idx,
                                                        input logic [ADDR_WIDTH-1:0] kb,
                                                        input logic [ADDR_WIDTH-1:0] pb);
        logic [ADDR_WIDTH-1:0] base;
        base = idx[4] ? pb : kb;
        return base + ADDR_WIDTH'(idx[3:0]);
    endfunction

    // Byte 0 is the most significant byte of the word.
    function automatic logic [DATA_WIDTH-1:0] get_byte(input logic [N-1:0] w,
                                                       input logic [3:0] idx);
        return w[(N-1) - DATA_WIDTH*int'(idx) -: DATA_WIDTH];
    endfunction

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign aes_start = aes_start_r;
    assign aes_key   = key_r;
    assign aes_pt    = pt_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;

    // Read-data capture: data returns one cycle after each granted read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_r <= 1'b0;
            rd_idx_r <= 5'd0;
            key_r    <= '0;
            pt_r     <= '0;
        end else begin
            rd_vld_r <= (state_r == S_LOAD) && mem_req_r && mem_gnt;
            rd_idx_r <= cnt_r;
            if (rd_vld_r) begin
                if (rd_idx_r[4]) begin
                    pt_r[(N-1) - DATA_WIDTH*int'(rd_idx_r[3:0]) -: DATA_WIDTH] <= mem_rdata;
                end else begin
                    key_r[(N-1) - DATA_WIDTH*int'(rd_idx_r[3:0]) -: DATA_WIDTH] <= mem_rdata;
                end
            end else begin
                key_r <= key_r;
                pt_r  <= pt_r;
            end
        end
    end

    // Sequencer FSM with registered memory, core and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            cnt_r       <= 5'd0;
            wait_cnt_r  <= '0;
            key_base_r  <= '0;
            pt_base_r   <= '0;
            ct_base_r   <= '0;
            ct_r        <= '0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            aes_start_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        key_base_r <= key_base;
                        pt_base_r  <= pt_base;
                        ct_base_r  <= ct_base;
                        err_r      <= 1'b0;
                        cnt_r      <= 5'd0;
                        wait_cnt_r <= '0;
                        mem_req_r  <= 1'b1;
                        mem_we_r   <= 1'b0;
                        mem_addr_r <= key_base;
                        busy_r     <= 1'b1;
                        state_r    <= S_LOAD;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    if (mem_gnt && (cnt_r == 5'd31)) begin
                        mem_req_r <= 1'b0;
                        state_r   <= S_DRAIN;
                    end else if (mem_gnt) begin
                        cnt_r      <= cnt_r + 5'd1;
                        mem_addr_r <= load_addr(cnt_r + 5'd1, key_base_r, pt_base_r);
                    end else begin
                        state_r <= S_LOAD;
                    end
                end
                S_DRAIN: begin
                    aes_start_r <= 1'b1;
                    state_r     <= S_RUN;
                end
                S_RUN: begin
                    aes_start_r <= 1'b0;
                    wait_cnt_r  <= '0;
                    state_r     <= S_WAIT;
                end
                S_WAIT: begin
                    if (aes_done) begin
                        ct_r        <= aes_ct;
                        cnt_r       <= 5'd0;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= ct_base_r;
                        mem_wdata_r <= get_byte(aes_ct, 4'd0);
                        state_r     <= S_STORE;
                    end else if (wait_cnt_r == WAIT_W'(TIMEOUT - 1)) begin
                        err_r   <= 1'b1;
                        done_r  <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                    end
                end
                S_STORE: begin
                    if (mem_gnt && (cnt_r == 5'd15)) begin
                        mem_req_r   <= 1'b0;
                        mem_we_r    <= 1'b0;
                        mem_wdata_r <= '0;
                        done_r      <= 1'b1;
                        state_r     <= S_DONE;
                    end else if (mem_gnt) begin
                        cnt_r       <= cnt_r + 5'd1;
                        mem_addr_r  <= ct_base_r + ADDR_WIDTH'(cnt_r[3:0] + 4'd1);
                        mem_wdata_r <= get_byte(ct_r, cnt_r[3:0] + 4'd1);
                    end else begin
                        state_r <= S_STORE;
                    end
                end
                S_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    mem_req_r   <= 1'b0;
                    mem_we_r    <= 1'b0;
                    aes_start_r <= 1'b0;
                    done_r      <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_mem_sequencer.sv
// Directed bench for aes_mem_sequencer: memory and AES core models around the DUT,
// FIPS-197 vector, random grants, address wrap, timeout, mid-store reset, ignored starts.
module tb_aes_mem_sequencer;

    localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [5:0]   key_base, pt_base, ct_base;
    logic         mem_req, mem_we;
    logic [5:0]   mem_addr;
    logic [7:0]   mem_wdata;
    logic         mem_gnt = 1'b1;
    logic [7:0]   mem_rdata = 8'h00;
    logic         aes_start;
    logic [127:0] aes_key, aes_pt;
    logic         aes_done = 1'b0;
    logic [127:0] aes_ct = 128'h0;
    logic         busy, done, err;

    int checks_cnt = 0;
    int errors_cnt = 0;

    logic [7:0] mem [64];
    logic [7:0] init_img [64];
    bit         load_img = 1'b0;
    logic [5:0] rd_log [$];
    logic [5:0] wr_log [$];
    int         done_cnt = 0;
    bit         gnt_rand = 1'b0;
    bit         aes_en = 1'b1;
    int         aes_cnt = 0;
    logic       prev_req = 1'b0, prev_gnt = 1'b1, prev_we = 1'b0;
    logic [5:0] prev_addr = 6'd0;
    logic [7:0] prev_wdata = 8'd0;

    aes_mem_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .key_base(key_base), .pt_base(pt_base), .ct_base(ct_base),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
        .aes_start(aes_start), .aes_key(aes_key), .aes_pt(aes_pt),
        .aes_done(aes_done), .aes_ct(aes_ct),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory model: one access per granted request, read data registered.
    always @(posedge clk) begin
        if (load_img) begin
            mem <= init_img;
            rd_log.delete();
            wr_log.delete();
            done_cnt <= 0;
        end else begin
            if (mem_req && mem_gnt) begin
                if (mem_we) begin
                    mem[mem_addr] <= mem_wdata;
                    wr_log.push_back(mem_addr);
                end else begin
                    mem_rdata <= mem[mem_addr];
                    rd_log.push_back(mem_addr);
                end
            end
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    // Ungranted requests must be held unchanged into the next cycle.
    always @(posedge clk) begin
        if (!rst && prev_req && !prev_gnt)
            check_eq("req_hold", {mem_req, mem_we, mem_addr, mem_wdata},
                     {1'b1, prev_we, prev_addr, prev_wdata});
        prev_req   <= mem_req;
        prev_gnt   <= mem_gnt;
        prev_we    <= mem_we;
        prev_addr  <= mem_addr;
        prev_wdata <= mem_wdata;
    end

    always @(negedge clk) mem_gnt <= gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;

    // AES core model: done pulse 10 cycles after the launch, ciphertext only with done.
    always @(posedge clk) begin
        if (aes_start && aes_en) aes_cnt <= 10;
        else if (aes_cnt != 0)   aes_cnt <= aes_cnt - 1;
        aes_done <= aes_en && (aes_cnt == 1);
        aes_ct   <= (aes_en && (aes_cnt == 1)) ? CT : 128'h0;
    end

    task automatic init_mem(input logic [5:0] kb, input logic [5:0] pb);
        logic [127:0] k, p;
        k = KEY;
        p = PT;
        for (int i = 0; i < 64; i++) init_img[i] = 8'hEE;
        for (int i = 0; i < 16; i++) begin
            init_img[6'(kb + 6'(i))] = k[127 - 8*i -: 8];
            init_img[6'(pb + 6'(i))] = p[127 - 8*i -: 8];
        end
        @(negedge clk); load_img = 1'b1;
        @(negedge clk); load_img = 1'b0;
    endtask

    task automatic run_op(input logic [5:0] kb, input logic [5:0] pb, input logic [5:0] cb,
                          input bit spur, output int dcyc);
        int n;
        key_base = kb; pt_base = pb; ct_base = cb;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0; n = 1;
        check_eq("load_c1", {err, busy, mem_req, mem_we, mem_addr}, {1'b0, 1'b1, 1'b1, 1'b0, kb});
        while (!done && n < 400) begin
            @(posedge clk); #1; n++;
            start = spur && (n == 38 || n == 62);
            if (spur && n == 38) begin
                key_base = 6'd5; pt_base = 6'd9; ct_base = 6'd1;
            end
        end
        dcyc = n;
        if (!done) check_eq("done_bound", 128'(done), 128'd1);
        @(posedge clk); #1; start = 1'b0;
        key_base = kb; pt_base = pb; ct_base = cb;
    endtask

    task automatic check_ct(input logic [5:0] cb);
        logic [127:0] obs;
        obs = '0;
        for (int i = 0; i < 16; i++) obs = {obs[119:0], mem[6'(cb + 6'(i))]};
        check_eq("ct_mem", obs, CT);
    endtask

    task automatic check_seq(input logic [5:0] kb, input logic [5:0] pb, input logic [5:0] cb,
                             input bit writes);
        int bad;
        bad = 0;
        check_eq("rd_cnt", 128'(rd_log.size()), 128'd32);
        check_eq("wr_cnt", 128'(wr_log.size()), writes ? 128'd16 : 128'd0);
        for (int i = 0; i < 32 && i < rd_log.size(); i++)
            if (rd_log[i] !== ((i < 16) ? 6'(kb + 6'(i)) : 6'(pb + 6'(i - 16)))) bad++;
        for (int i = 0; i < 16 && i < wr_log.size(); i++)
            if (wr_log[i] !== 6'(cb + 6'(i))) bad++;
        check_eq("addr_seq", 128'(bad), 128'd0);
    endtask

    initial begin
        int d;
        rst = 1'b0; start = 1'b0;
        key_base = 6'd0; pt_base = 6'd0; ct_base = 6'd0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_outs", {mem_req, mem_we, mem_addr, mem_wdata, aes_start, busy, done, err}, 128'd0);
        check_eq("rst_key_pt", {aes_key, aes_pt} == 256'd0 ? 128'd1 : 128'd0, 128'd1);
        @(negedge clk); rst = 1'b0;

        // FIPS-197 vector, grant always high
        init_mem(6'd0, 6'd16);
        run_op(6'd0, 6'd16, 6'd32, 1'b0, d);
        check_eq("fips_done_cyc", 128'(d), 128'd62);
        check_eq("fips_key", aes_key, KEY);
        check_eq("fips_pt", aes_pt, PT);
        check_eq("fips_err_busy", {err, busy}, 128'd0);
        check_ct(6'd32);
        check_seq(6'd0, 6'd16, 6'd32, 1'b1);
        check_eq("fips_done_cnt", 128'(done_cnt), 128'd1);

        // Same vector, random 50% grant
        init_mem(6'd0, 6'd16);
        gnt_rand = 1'b1;
        run_op(6'd0, 6'd16, 6'd32, 1'b0, d);
        gnt_rand = 1'b0;
        check_eq("rnd_key", aes_key, KEY);
        check_eq("rnd_pt", aes_pt, PT);
        check_ct(6'd32);
        check_seq(6'd0, 6'd16, 6'd32, 1'b1);

        // Address wrap on plaintext read and ciphertext write
        init_mem(6'd0, 6'd56);
        run_op(6'd0, 6'd56, 6'd60, 1'b0, d);
        check_eq("wrap_done_cyc", 128'(d), 128'd62);
        check_eq("wrap_pt", aes_pt, PT);
        check_ct(6'd60);
        check_seq(6'd0, 6'd56, 6'd60, 1'b1);

        // Core never completes: timeout
        aes_en = 1'b0;
        init_mem(6'd0, 6'd16);
        run_op(6'd0, 6'd16, 6'd32, 1'b0, d);
        check_eq("to_done_cyc", 128'(d), 128'd99);
        repeat (3) @(posedge clk);
        #1;
        check_eq("to_err_held", {err, busy}, {1'b1, 1'b0});
        check_seq(6'd0, 6'd16, 6'd32, 1'b0);
        aes_en = 1'b1;
        init_mem(6'd0, 6'd16);
        run_op(6'd0, 6'd16, 6'd32, 1'b0, d);
        check_eq("after_to_cyc", 128'(d), 128'd62);
        check_eq("after_to_err", 128'(err), 128'd0);
        check_ct(6'd32);

        // Reset after the 5th ciphertext write
        init_mem(6'd0, 6'd16);
        key_base = 6'd0; pt_base = 6'd16; ct_base = 6'd40;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        d = 0;
        while (wr_log.size() < 5 && d < 200) begin
            @(posedge clk); #1; d++;
        end
        check_eq("rst_wr5_seen", 128'(wr_log.size()), 128'd5);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_mid_outs", {mem_req, mem_we, mem_addr, mem_wdata, aes_start, busy, done, err}, 128'd0);
        check_eq("rst_mid_key", aes_key, 128'd0);
        @(negedge clk); rst = 1'b0;
        check_eq("rst_mem_part", {mem[40], mem[41], mem[42], mem[43], mem[44], mem[45]},
                 {8'h39, 8'h25, 8'h84, 8'h1d, 8'h02, 8'hEE});
        check_eq("rst_wr_total", 128'(wr_log.size()), 128'd5);
        init_mem(6'd0, 6'd16);
        run_op(6'd0, 6'd16, 6'd32, 1'b0, d);
        check_eq("post_rst_cyc", 128'(d), 128'd62);
        check_ct(6'd32);

        // start pulses during WAIT and DONE are ignored
        init_mem(6'd0, 6'd16);
        run_op(6'd0, 6'd16, 6'd32, 1'b1, d);
        check_eq("spur_done_cyc", 128'(d), 128'd62);
        repeat (5) @(posedge clk);
        #1;
        check_eq("spur_idle", {busy, mem_req}, 128'd0);
        check_eq("spur_done_cnt", 128'(done_cnt), 128'd1);
        check_eq("spur_key", aes_key, KEY);
        check_ct(6'd32);
        check_seq(6'd0, 6'd16, 6'd32, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
